// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side character buffer behind the UART receiver. Each completed
// character is stored with its parity and framing flags in a circular FIFO.
// The oldest entry is presented on a first-word-fall-through valid/ready port.
// A sticky overrun flag and a saturating drop counter record discarded characters.

module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_parity_err,
  input  logic                       in_frame_err,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       rd_parity_err,
  output logic                       rd_frame_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overrun,
  output logic [7:0]                 drop_count,
  input  logic                       overrun_clr
);

  // Low pointer bits address the memory; the extra MSB is the wrap bit that
  // tells "full" apart from "empty" when the low bits are equal.
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = DATA_BITS + 2;

  // Entry layout: {frame_err, parity_err, data}
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic                 frame_err,
    input logic                 parity_err,
    input logic [DATA_BITS-1:0] data
  );
    return {frame_err, parity_err, data};
  endfunction

  logic                 in_prev_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic                 overrun_r;
  logic [7:0]           drop_count_r;
  logic [ENTRY_W-1:0]   mem_r [DEPTH];

  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 accept_s;
  logic                 drop_s;
  logic [PTR_W-1:0]     wr_ptr_nxt_s;
  logic [PTR_W-1:0]     rd_ptr_nxt_s;
  logic                 overrun_nxt_s;
  logic [7:0]           drop_count_nxt_s;
  logic [ENTRY_W-1:0]   head_s;

  // Flags come straight from the registered pointers, so they never glitch.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                   (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);

  // The receiver holds in_valid for many cycles; only its rising edge writes.
  assign push_s   = in_valid & ~in_prev_r;
  assign pop_s    = ~empty_s & rd_ready;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign accept_s = push_s & (~full_s | pop_s);
  assign drop_s   = push_s & full_s & ~pop_s;

  // Next-state for pointers and the overrun bookkeeping.
  always_comb begin
    wr_ptr_nxt_s     = wr_ptr_r;
    rd_ptr_nxt_s     = rd_ptr_r;
    overrun_nxt_s    = overrun_r;
    drop_count_nxt_s = drop_count_r;

    if (accept_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    // A drop in the same cycle as a clear wins: the clear restarts the count
    // and this drop is counted as the first one.
    if (drop_s) begin
      overrun_nxt_s = 1'b1;
      if (overrun_clr) begin
        drop_count_nxt_s = 8'd1;
      end else if (drop_count_r != 8'd255) begin
        drop_count_nxt_s = drop_count_r + 8'd1;
      end else begin
        drop_count_nxt_s = drop_count_r;
      end
    end else if (overrun_clr) begin
      overrun_nxt_s    = 1'b0;
      drop_count_nxt_s = 8'd0;
    end else begin
      overrun_nxt_s    = overrun_r;
      drop_count_nxt_s = drop_count_r;
    end
  end

  // Control state: asynchronous reset discards all buffered characters at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_prev_r    <= 1'b0;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      overrun_r    <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      in_prev_r    <= in_valid;
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      overrun_r    <= overrun_nxt_s;
      drop_count_r <= drop_count_nxt_s;
    end
  end

  // Storage array; contents are left unreset, validity is tracked by pointers.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= pack_entry(in_frame_err, in_parity_err, in_data);
    end
  end

  // First-word-fall-through: the head entry is read combinationally.
  assign head_s        = mem_r[rd_ptr_r[ADDR_W-1:0]];
  assign rd_data       = head_s[DATA_BITS-1:0];
  assign rd_parity_err = head_s[DATA_BITS];
  assign rd_frame_err  = head_s[DATA_BITS+1];

  assign rd_valid   = ~empty_s;
  assign empty      = empty_s;
  assign full       = full_s;
  assign count      = wr_ptr_r - rd_ptr_r;
  assign overrun    = overrun_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (DATA_BITS=8, DEPTH=16): a vector table for
// the single-cycle behaviour, then hand-written multi-cycle sequences.

module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_parity_err;
  logic       in_frame_err;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_frame_err;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overrun;
  logic [7:0] drop_count;
  logic       overrun_clr;

  int n_tests;
  int n_fail;

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_parity_err (in_parity_err),
    .in_frame_err  (in_frame_err),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_parity_err (rd_parity_err),
    .rd_frame_err  (rd_frame_err),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overrun       (overrun),
    .drop_count    (drop_count),
    .overrun_clr   (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       rr;
    logic       ev;     // expected rd_valid after the edge
    logic [4:0] ecnt;   // expected count after the edge
    logic [9:0] ehead;  // expected {fe,pe,data} of head, checked when ev
  } vec_t;

  vec_t vecs[$];
  logic [9:0] sb[$];

  function automatic vec_t mkv(logic v, logic [7:0] d, logic pe, logic fe, logic rr,
                               logic ev, logic [4:0] ecnt, logic [9:0] ehead);
    vec_t t;
    t.v = v; t.d = d; t.pe = pe; t.fe = fe; t.rr = rr;
    t.ev = ev; t.ecnt = ecnt; t.ehead = ehead;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, sample 1ns after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic pe, input logic fe,
                     input logic rr, input logic clr);
    @(negedge clk);
    in_valid = v; in_data = d; in_parity_err = pe; in_frame_err = fe;
    rd_ready = rr; overrun_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // One character: a single-cycle in_valid pulse followed by an idle cycle.
  task automatic push_char(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [9:0] head();
    return {rd_frame_err, rd_parity_err, rd_data};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_parity_err = 1'b0; in_frame_err = 1'b0;
    rd_ready = 1'b0; overrun_clr = 1'b0;

    // Single char held 20 cycles: one push only.
    vecs.push_back(mkv(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 10'h05A));
    for (int i = 0; i < 19; i++)
      vecs.push_back(mkv(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 10'h05A));
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'h000));
    // Flags travel with their character.
    vecs.push_back(mkv(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 10'h13C));
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 10'h13C));
    vecs.push_back(mkv(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 10'h13C));
    vecs.push_back(mkv(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 10'h281));
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'h000));
    // Simultaneous push and pop on a non-full FIFO.
    vecs.push_back(mkv(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 10'h011));
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 10'h011));
    vecs.push_back(mkv(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 10'h322));
    vecs.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'h000));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].pe, vecs[i].fe, vecs[i].rr, 1'b0);
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      if (vecs[i].ev)
        chk($sformatf("vec%0d_head", i), 32'(head()), 32'(vecs[i].ehead));
    end
    chk("tbl_empty", 32'(empty), 32'd1);

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) push_char(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_overrun", 32'(overrun), 32'd0);

    // Three drops.
    push_char(8'hA0); push_char(8'hA1); push_char(8'hA2);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_drops", 32'(drop_count), 32'd3);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_head", 32'(head()), 32'h000);

    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_flag", 32'(overrun), 32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);
    // Clear and drop in the same cycle: the drop wins.
    cyc(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clrdrop_flag", 32'(overrun), 32'd1);
    chk("clrdrop_drops", 32'(drop_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr2_flag", 32'(overrun), 32'd0);
    chk("clr2_drops", 32'(drop_count), 32'd0);

    // Full FIFO, push 0x77 while popping 0x00.
    chk("simul_pre_head", 32'(head()), 32'h000);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("simul_count", 32'(count), 32'd16);
    chk("simul_full", 32'(full), 32'd1);
    chk("simul_overrun", 32'(overrun), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("drain_head%0d", k), 32'(head()), 32'(k));
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_last", 32'(head()), 32'h077);
    chk("drain_last_count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_rd_valid", 32'(rd_valid), 32'd0);

    // 40 chars through the ring with flag patterns and interleaved pops.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ib;
      logic       pe;
      logic       fe;
      ib = 8'(i);
      pe = ib[0];
      fe = ib[1] ^ ib[2];
      cyc(1'b1, 8'h40 + ib, pe, fe, 1'b0, 1'b0);
      sb.push_back({fe, pe, 8'h40 + ib});
      if ((i % 3) != 0) begin
        chk($sformatf("wrap_pop%0d", i), 32'(head()), 32'(sb[0]));
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
      end else begin
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("wrap_count", 32'(count), 32'(sb.size()));
    while (sb.size() > 0) begin
      chk("wrap_drain", 32'(head()), 32'(sb[0]));
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // 260 drops saturate the counter.
    for (int i = 0; i < 16; i++) push_char(8'(i));
    for (int i = 0; i < 260; i++) push_char(8'hEE);
    chk("sat_drops", 32'(drop_count), 32'd255);
    chk("sat_overrun", 32'(overrun), 32'd1);
    chk("sat_count", 32'(count), 32'd16);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_head", 32'(head()), 32'h00B);

    // Asynchronous reset mid-cycle, in_valid high across release.
    @(negedge clk);
    rd_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_drops", 32'(drop_count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_push_count", 32'(count), 32'd1);
    chk("post_rst_push_head", 32'(head()), 32'h0C3);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_hold_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
